// File: rtl/mult_seq_ctrl_if.sv
// Handshake/operand bundle between the control unit (master) and the
// sequential multiplier (slave).
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add MULT/MULTU sequencer: one adder pass per cycle, signed via magnitude + final negate.
// Optional MULT_ZERO_BYPASS_EN: zero operands skip the iteration phase.
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          reset,
    mult_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_nx;
    logic [WIDTH-1:0]   acc, mreg, mcand;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [CNT_W-1:0]   cnt;
    logic               neg, done_q;
    logic               load, step, finish, busy;
    logic               zero_op;
    logic [WIDTH-1:0]   abs_a, abs_b, addend, res;
    logic               cout;
    logic [2*WIDTH-1:0] prod_raw, product;

    always_comb begin
        abs_a = (bus.is_signed && bus.op_a[WIDTH-1]) ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
        abs_b = (bus.is_signed && bus.op_b[WIDTH-1]) ? (~bus.op_b + WIDTH'(1)) : bus.op_b;
`ifdef MULT_ZERO_BYPASS_EN
        zero_op = (bus.op_a == '0) || (bus.op_b == '0);
`else
        zero_op = 1'b0;
`endif
    end

    // Single adder: accumulate partial product selected by the multiplier LSB.
    always_comb begin
        addend      = mreg[0] ? mcand : '0;
        {cout, res} = {1'b0, acc} + {1'b0, addend};
        prod_raw    = {acc, mreg};
        product     = neg ? (~prod_raw + (2*WIDTH)'(1)) : prod_raw;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = zero_op ? FIX : RUN;
            RUN:     if (cnt == LAST) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        busy   = 1'b0;
        case (state)
            IDLE:    load = bus.start;
            RUN:     begin step = 1'b1;   busy = 1'b1; end
            FIX:     begin finish = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mreg   <= '0;
            mcand  <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                acc   <= '0;
                cnt   <= '0;
                mcand <= zero_op ? '0 : abs_a;
                mreg  <= zero_op ? '0 : abs_b;
                neg   <= ~zero_op & bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            end
            if (step) begin
                // 65-bit {cout,res,mreg} shifted right by one, low 64 bits kept.
                acc  <= {cout, res[WIDTH-1:1]};
                mreg <= {res[0], mreg[WIDTH-1:1]};
                cnt  <= cnt + CNT_W'(1);
            end
            if (finish) begin
                hi_q   <= product[2*WIDTH-1:WIDTH];
                lo_q   <= product[WIDTH-1:0];
                done_q <= 1'b1;
            end
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed table, random ops against a
// plain-arithmetic product model, and handshake corner sequences.
module tb_mult_seq_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_seq_ctrl_if #(.WIDTH(32)) bus ();
    mult_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_BYPASS_EN
        if (a == 0 || b == 0) return 1;
`endif
        return 33;
    endfunction

    // Issues one request; lat = edges after the start edge until done is seen (-1 on timeout).
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo, output int lat);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.op_a      = a;
        bus.op_b      = b;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.op_a      = $urandom();
        bus.op_b      = $urandom();
        bus.is_signed = 1'($urandom_range(0, 1));
        check("busy_after_start", 64'(bus.busy), 64'd1);
        lat = -1;
        rhi = '0;
        rlo = '0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                rhi = bus.hi;
                rlo = bus.lo;
                break;
            end
        end
    endtask

    vec_t        vecs[6];
    logic [31:0] rhi, rlo, ra, rb;
    logic        rs;
    int          lat, done_cnt, first_done;

    initial begin
        vecs[0] = '{"multu_7x6",    1'b0, 32'd7,        32'd6,        32'h00000000, 32'h0000002A};
        vecs[1] = '{"multu_max",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{"mult_m1xm1",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[3] = '{"mult_minx2",   1'b1, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000};
        vecs[4] = '{"mult_m3x5",    1'b1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[5] = '{"multu_zero",   1'b0, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000};

        reset = 1'b1;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_hi",   64'(bus.hi),   64'd0);
        check("reset_lo",   64'(bus.lo),   64'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, rhi, rlo, lat);
            check({vecs[i].name, "_hi"}, 64'(rhi), 64'(vecs[i].hi));
            check({vecs[i].name, "_lo"}, 64'(rlo), 64'(vecs[i].lo));
            check_int({vecs[i].name, "_lat"}, lat, exp_latency(vecs[i].a, vecs[i].b));
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(bus.done), 64'd0);
        check("hi_lo_held", {bus.hi, bus.lo}, 64'd0);

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom();
            rb = $urandom();
            if (i == 3) ra = 32'h80000000;
            if (i == 4) rb = 32'h80000000;
            if (i == 5) ra = 32'd0;
            run_op(rs, ra, rb, rhi, rlo, lat);
            check("rand_prod", {rhi, rlo}, ref_prod(rs, ra, rb));
            check_int("rand_lat", lat, exp_latency(ra, rb));
        end

        // Second start at E10 must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd3; bus.op_b = 32'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op_a = 32'd9; bus.op_b = 32'd9;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check("busy_at_e10", 64'(bus.busy), 64'd1);
        done_cnt = 0;
        first_done = -1;
        for (int n = 11; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = n;
                    rhi = bus.hi;
                    rlo = bus.lo;
                end
            end
        end
        check_int("ignore_done_count", done_cnt, 1);
        check_int("ignore_done_edge", first_done, 33);
        check("ignore_result", {rhi, rlo}, 64'd12);

        // Reset sampled at E15 aborts the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd3; bus.op_b = 32'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        done_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) done_cnt++;
        end
        check_int("abort_no_done", done_cnt, 0);
        run_op(1'b0, 32'd5, 32'd5, rhi, rlo, lat);
        check("after_abort_result", {rhi, rlo}, 64'd25);
        check_int("after_abort_lat", lat, 33);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
